rx_interface: RTL and testbench

RX_INTERFACE -- requirements
Module: rx_interface

---
 rtl/rx_interface_if.sv | 22 ++
 rtl/rx_interface.sv | 129 ++++++++++++
 tb/tb_rx_interface.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rx_interface_if.sv
// Receive-side bundle between the gearbox output and the meta-frame aligner.
// The master drives received words; the slave returns payload and status.
interface rx_interface_if;
  logic [63:0] dataIn;
  logic [1:0]  headerIn;
  logic        dataValidIn;
  logic [63:0] dataOut;
  logic        dataOutValid;
  logic        frameLock;
  logic        syncErr;
  logic        headerErr;

  modport master (
    output dataIn, headerIn, dataValidIn,
    input  dataOut, dataOutValid, frameLock, syncErr, headerErr
  );

  modport slave (
    input  dataIn, headerIn, dataValidIn,
    output dataOut, dataOutValid, frameLock, syncErr, headerErr
  );
endinterface

// File: rtl/rx_interface.sv
// Meta-frame aligner: hunts for the sync word, verifies it over LOCK_CNT frames,
// then forwards payload words while locked and drops lock after LOSS_CNT bad syncs.
module rx_interface #(
  parameter int META_FRAME_LEN = 16,
  parameter int LOCK_CNT       = 4,
  parameter int LOSS_CNT       = 4
) (
  input logic          user_clk_i,
  input logic          system_reset_n_i,
  rx_interface_if.slave rxIf
);

  localparam int PW      = (META_FRAME_LEN > 1) ? $clog2(META_FRAME_LEN) : 1;
  localparam int CNT_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [PW-1:0] POS_LAST = PW'(META_FRAME_LEN - 1);
  localparam logic [CW-1:0] LOCK_C   = CW'(LOCK_CNT);
  localparam logic [CW-1:0] LOSS_C   = CW'(LOSS_CNT);
  localparam logic [63:0]   SYNC_WORD = 64'h78F678F678F678F6;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  state_e        state_q;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] goodCnt_q, goodCnt_d;
  logic [CW-1:0] badCnt_q, badCnt_d;
  logic [63:0]   dataOut_q;
  logic          dataOutValid_q;
  logic          frameLock_q;
  logic          syncErr_q;
  logic          headerErr_q;

  logic isSync, isScram, isData, isBadHdr, atPos0, atPos1;

  // IDLE and any other control words need no dedicated flag: they are simply not DATA.
  always_comb begin
    isSync    = (rxIf.headerIn == 2'b10) && (rxIf.dataIn == SYNC_WORD);
    isScram   = (rxIf.headerIn == 2'b10) && (rxIf.dataIn[63:56] == 8'h28);
    isData    = (rxIf.headerIn == 2'b01);
    isBadHdr  = (rxIf.headerIn == 2'b00) || (rxIf.headerIn == 2'b11);
    atPos0    = (pos_q == '0);
    atPos1    = (pos_q == PW'(1));
    pos_d     = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
    goodCnt_d = (goodCnt_q < LOCK_C) ? goodCnt_q + CW'(1) : goodCnt_q;
    badCnt_d  = (badCnt_q < LOSS_C) ? badCnt_q + CW'(1) : badCnt_q;
  end

  always_ff @(posedge user_clk_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      state_q        <= HUNT;
      pos_q          <= '0;
      goodCnt_q      <= '0;
      badCnt_q       <= '0;
      dataOut_q      <= '0;
      dataOutValid_q <= 1'b0;
      frameLock_q    <= 1'b0;
      syncErr_q      <= 1'b0;
      headerErr_q    <= 1'b0;
    end else begin
      dataOutValid_q <= 1'b0;
      syncErr_q      <= 1'b0;
      headerErr_q    <= 1'b0;
      if (rxIf.dataValidIn) begin
        headerErr_q <= isBadHdr;
        pos_q       <= pos_d;
        case (state_q)
          HUNT: begin
            if (isSync) begin
              pos_q     <= PW'(1);
              goodCnt_q <= CW'(1);
              state_q   <= VERIFY;
            end
          end
          VERIFY: begin
            if (atPos0) begin
              if (isSync) begin
                goodCnt_q <= goodCnt_d;
                if (goodCnt_d >= LOCK_C) begin
                  state_q     <= LOCKED;
                  badCnt_q    <= '0;
                  frameLock_q <= 1'b1;
                end
              end else begin
                state_q   <= HUNT;
                goodCnt_q <= '0;
              end
            end else if (atPos1 && !isScram) begin
              state_q   <= HUNT;
              goodCnt_q <= '0;
            end
          end
          LOCKED: begin
            // A sync pattern past pos 1 is treated as ordinary control: no realignment.
            if (atPos0) begin
              if (isSync) begin
                badCnt_q <= '0;
              end else begin
                syncErr_q <= 1'b1;
                badCnt_q  <= badCnt_d;
                if (badCnt_d >= LOSS_C) begin
                  state_q     <= HUNT;
                  frameLock_q <= 1'b0;
                  goodCnt_q   <= '0;
                end
              end
            end else if (atPos1) begin
              if (!isScram) syncErr_q <= 1'b1;
            end else if (isData) begin
              dataOut_q      <= rxIf.dataIn;
              dataOutValid_q <= 1'b1;
            end
          end
          default: begin
            state_q     <= HUNT;
            frameLock_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rxIf.dataOut      = dataOut_q;
  assign rxIf.dataOutValid = dataOutValid_q;
  assign rxIf.frameLock    = frameLock_q;
  assign rxIf.syncErr      = syncErr_q;
  assign rxIf.headerErr    = headerErr_q;

endmodule

// File: tb/tb_rx_interface.sv
// Directed bench for rx_interface: lock acquisition, gapped valid, loss and
// recovery of lock, idle/illegal-header handling and mid-frame reset.
module tb_rx_interface;

  localparam logic [63:0] SYNC_W  = 64'h78F678F678F678F6;
  localparam logic [63:0] BAD_W   = 64'h78F678F678F678F7;
  localparam logic [63:0] SCRAM_W = 64'h2800_0000_0000_0123;
  localparam logic [63:0] IDLE_W  = 64'hAAAAAAAAAAAAAAAA;

  logic clk;
  logic rstN;

  int checks   = 0;
  int failures = 0;

  logic [63:0] expOut  = '0;
  bit          curLock = 0;
  bit          gapMode = 0;
  int          gapCnt  = 0;

  rx_interface_if rxIf ();

  rx_interface #(
    .META_FRAME_LEN(16),
    .LOCK_CNT(4),
    .LOSS_CNT(4)
  ) dut (
    .user_clk_i(clk),
    .system_reset_n_i(rstN),
    .rxIf(rxIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] hdr, input logic [63:0] data, input logic valid);
    rxIf.headerIn    = hdr;
    rxIf.dataIn      = data;
    rxIf.dataValidIn = valid;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input bit expValid, input bit expLock,
                             input bit expSyncErr, input bit expHdrErr);
    logic [67:0] obs;
    logic [67:0] exp;
    obs = {rxIf.dataOutValid, rxIf.dataOut, rxIf.frameLock, rxIf.syncErr, rxIf.headerErr};
    exp = {expValid, expOut, expLock, expSyncErr, expHdrErr};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed(valid,data,lock,syncErr,hdrErr)=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends nWords of a 16-word frame; pos specPos may carry a substituted word.
  task automatic sendFrame(input string tag, input logic [63:0] syncData, input bit expLock,
                           input bit expSyncErr, input bit expPayload, input int nWords,
                           input int specPos, input logic [1:0] specHdr,
                           input logic [63:0] specData, input bit specHdrErr);
    logic [1:0]  h;
    logic [63:0] d;
    bit          ev, es, eh;
    for (int p = 0; p < nWords; p++) begin
      if (gapMode && gapCnt == 2) begin
        applyStimulus(2'b00, 64'hDEAD_BEEF_0000_0000, 1'b0);
        checkOutput($sformatf("%s_gap%0d", tag, p), 1'b0, curLock, 1'b0, 1'b0);
        gapCnt = 0;
      end
      ev = 0; es = 0; eh = 0;
      if (p == 0) begin
        h = 2'b10; d = syncData; es = expSyncErr;
      end else if (p == 1) begin
        h = 2'b10; d = SCRAM_W;
      end else if (p == specPos) begin
        h = specHdr; d = specData; eh = specHdrErr;
      end else begin
        h = 2'b01; d = 64'(p - 1); ev = expPayload;
      end
      applyStimulus(h, d, 1'b1);
      gapCnt++;
      if (p == 0) curLock = expLock;
      if (ev) expOut = d;
      checkOutput($sformatf("%s_p%0d", tag, p), ev, curLock, es, eh);
    end
  endtask

  task automatic goodFrame(input string tag, input bit expLock, input bit expPayload);
    sendFrame(tag, SYNC_W, expLock, 1'b0, expPayload, 16, -1, 2'b01, 64'h0, 1'b0);
  endtask

  task automatic badFrame(input string tag, input bit expLock, input bit expPayload);
    sendFrame(tag, BAD_W, expLock, 1'b1, expPayload, 16, -1, 2'b01, 64'h0, 1'b0);
  endtask

  task automatic doReset(input string tag);
    rxIf.dataValidIn = 1'b0;
    rstN = 1'b0;
    #2;
    expOut  = '0;
    curLock = 0;
    checkOutput(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rstN   = 1'b1;
    gapCnt = 0;
  endtask

  initial begin
    rstN             = 1'b0;
    rxIf.dataIn      = '0;
    rxIf.headerIn    = 2'b00;
    rxIf.dataValidIn = 1'b0;
    #3;
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Clean stream: lock on the 4th sync, payload from that frame on
    goodFrame("clean1", 1'b0, 1'b0);
    goodFrame("clean2", 1'b0, 1'b0);
    goodFrame("clean3", 1'b0, 1'b0);
    goodFrame("clean4", 1'b1, 1'b1);
    goodFrame("clean5", 1'b1, 1'b1);

    // Gapped valid, starting from reset
    doReset("rstGap");
    gapMode = 1;
    goodFrame("gap1", 1'b0, 1'b0);
    goodFrame("gap2", 1'b0, 1'b0);
    goodFrame("gap3", 1'b0, 1'b0);
    goodFrame("gap4", 1'b1, 1'b1);
    goodFrame("gap5", 1'b1, 1'b1);
    gapMode = 0;

    // Loss of lock after four corrupted syncs, then relock
    badFrame("loss1", 1'b1, 1'b1);
    badFrame("loss2", 1'b1, 1'b1);
    badFrame("loss3", 1'b1, 1'b1);
    badFrame("loss4", 1'b0, 1'b0);
    goodFrame("relock1", 1'b0, 1'b0);
    goodFrame("relock2", 1'b0, 1'b0);
    goodFrame("relock3", 1'b0, 1'b0);
    goodFrame("relock4", 1'b1, 1'b1);

    // Three bad syncs then a good one clear the loss counter
    badFrame("rec1", 1'b1, 1'b1);
    badFrame("rec2", 1'b1, 1'b1);
    badFrame("rec3", 1'b1, 1'b1);
    goodFrame("rec4", 1'b1, 1'b1);
    badFrame("rec5", 1'b1, 1'b1);
    badFrame("rec6", 1'b1, 1'b1);
    badFrame("rec7", 1'b1, 1'b1);
    goodFrame("rec8", 1'b1, 1'b1);

    // IDLE at pos 3, then an illegal header at pos 5, lock retained
    sendFrame("idle", SYNC_W, 1'b1, 1'b0, 1'b1, 16, 3, 2'b10, IDLE_W, 1'b0);
    sendFrame("hdr11", SYNC_W, 1'b1, 1'b0, 1'b1, 16, 5, 2'b11, 64'h5, 1'b1);
    goodFrame("postHdr", 1'b1, 1'b1);

    // Reset while locked with pos 7 next; alignment must be rebuilt
    sendFrame("partial", SYNC_W, 1'b1, 1'b0, 1'b1, 7, -1, 2'b01, 64'h0, 1'b0);
    doReset("rstMid");
    goodFrame("after1", 1'b0, 1'b0);
    goodFrame("after2", 1'b0, 1'b0);
    goodFrame("after3", 1'b0, 1'b0);
    goodFrame("after4", 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
